// File: rtl/core_sched.sv
// Thread scheduler: owns the core-enable vector, allocates the lowest free core on fork,
// retires cores on halt and round-robin arbitrates the shared data-memory port.
module core_sched #(
    parameter int NCORES = 4,
    parameter int PTR_W  = 16,
    parameter int PC_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fork_req,
    input  logic [PTR_W-1:0]  fork_ptr,
    input  logic [PC_W-1:0]   fork_pc,
    output logic              fork_ack,
    input  logic [NCORES-1:0] halt,
    input  logic [NCORES-1:0] mem_req,
    output logic [NCORES-1:0] mem_gnt,
    output logic [NCORES-1:0] core_ens,
    output logic [NCORES-1:0] start_stb,
    output logic [PTR_W-1:0]  start_ptr,
    output logic [PC_W-1:0]   start_pc,
    output logic              idle
);

    localparam int IDX_W = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [NCORES-1:0] ONE_HOT0 = {{(NCORES-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        F_IDLE  = 1'b0,
        F_START = 1'b1
    } fstate_e;

    fstate_e           state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  rr_last_q, rr_last_d;
    logic [NCORES-1:0] core_ens_q, core_ens_d;
    logic [NCORES-1:0] mem_gnt_q, mem_gnt_d;
    logic [NCORES-1:0] start_stb_q, start_stb_d;
    logic [PTR_W-1:0]  start_ptr_q, start_ptr_d;
    logic [PC_W-1:0]   start_pc_q, start_pc_d;
    logic              fork_ack_q, fork_ack_d;
    logic              idle_q, idle_d;
    logic [NCORES-1:0] free_s;
    logic [NCORES-1:0] elig_s;
    logic [NCORES-1:0] pick_s;
    logic [IDX_W-1:0]  sel_idx_s;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NCORES-1:0] v);
        lowest_idx = '0;
        for (int i = NCORES - 1; i >= 0; i--) begin
            if (v[IDX_W'(i)]) lowest_idx = IDX_W'(i);
        end
    endfunction

    // Scan starts just past the previous grantee so every requester gets a turn.
    function automatic logic [NCORES-1:0] rr_pick(input logic [NCORES-1:0] v,
                                                  input logic [IDX_W-1:0]  last);
        logic found;
        int   j;
        found   = 1'b0;
        rr_pick = '0;
        for (int k = 1; k <= NCORES; k++) begin
            j = (int'(last) + k) % NCORES;
            if (!found && v[IDX_W'(j)]) begin
                found               = 1'b1;
                rr_pick[IDX_W'(j)]  = 1'b1;
            end
        end
    endfunction

    assign free_s    = ~core_ens_q;
    assign sel_idx_s = lowest_idx(free_s);
    assign elig_s    = mem_req & core_ens_q & ~halt;
    assign pick_s    = rr_pick(elig_s, rr_last_q);

    // Fork FSM state register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= F_IDLE;
            idx_q       <= '0;
            rr_last_q   <= IDX_W'(NCORES - 1);
            core_ens_q  <= ONE_HOT0;
            mem_gnt_q   <= '0;
            start_stb_q <= '0;
            start_ptr_q <= '0;
            start_pc_q  <= '0;
            fork_ack_q  <= 1'b0;
            idle_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_last_q   <= rr_last_d;
            core_ens_q  <= core_ens_d;
            mem_gnt_q   <= mem_gnt_d;
            start_stb_q <= start_stb_d;
            start_ptr_q <= start_ptr_d;
            start_pc_q  <= start_pc_d;
            fork_ack_q  <= fork_ack_d;
            idle_q      <= idle_d;
        end
    end

    // Fork FSM next state: a request stalls while every core is busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            F_IDLE: begin
                if (fork_req && (|free_s)) state_d = F_START;
                else                       state_d = F_IDLE;
            end
            F_START: state_d = F_IDLE;
            default: state_d = F_IDLE;
        endcase
    end

    // Next values of the registered outputs, fork payload and arbiter.
    always_comb begin
        idx_d       = idx_q;
        fork_ack_d  = 1'b0;
        start_stb_d = '0;
        start_ptr_d = start_ptr_q;
        start_pc_d  = start_pc_q;
        core_ens_d  = core_ens_q & ~halt;
        if (state_q == F_START) begin
            core_ens_d = core_ens_d | (ONE_HOT0 << idx_q);
        end else begin
            core_ens_d = core_ens_d;
        end
        if ((state_q == F_IDLE) && (state_d == F_START)) begin
            idx_d       = sel_idx_s;
            fork_ack_d  = 1'b1;
            start_stb_d = ONE_HOT0 << sel_idx_s;
            start_ptr_d = fork_ptr;
            start_pc_d  = fork_pc;
        end else begin
            idx_d = idx_q;
        end
        if (|(mem_gnt_q & elig_s)) begin
            mem_gnt_d = mem_gnt_q;
            rr_last_d = rr_last_q;
        end else if (|pick_s) begin
            mem_gnt_d = pick_s;
            rr_last_d = lowest_idx(pick_s);
        end else begin
            mem_gnt_d = '0;
            rr_last_d = rr_last_q;
        end
        idle_d = (core_ens_d == '0) && (state_d == F_IDLE);
    end

    assign fork_ack  = fork_ack_q;
    assign mem_gnt   = mem_gnt_q;
    assign core_ens  = core_ens_q;
    assign start_stb = start_stb_q;
    assign start_ptr = start_ptr_q;
    assign start_pc  = start_pc_q;
    assign idle      = idle_q;

endmodule
